// File: rtl/rr_arbiter_4ch.sv
// rr_arbiter_4ch
// Four-requester round-robin arbiter with a per-tenure hold limit.
// Produces a registered one-hot grant, its encoded index, a valid flag and
// a one-cycle preempt pulse when a holder is forced off by the hold limit.
// Optional feature macro: RR_ARB_LOCK_EN adds a 'lock' input that lets the
// current owner keep the grant past MAX_HOLD for as long as it requests.

module rr_arbiter_4ch #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
`ifdef RR_ARB_LOCK_EN
  input  logic       lock,
`endif
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       preempt
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] hold_cnt;
  logic [1:0] rr_ptr;

  logic       lock_act;
  logic [3:0] req_rot;
  logic [1:0] arb_off;
  logic [1:0] arb_idx;
  logic       arb_found;
  logic       owner_req;
  logic       at_limit;
  logic       keep;
  logic       timeout;

`ifdef RR_ARB_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // Rotate the request vector so bit 0 is always the current top-priority requester.
  always_comb begin
    req_rot = req;
    case (rr_ptr)
      2'd0:    req_rot = req;
      2'd1:    req_rot = {req[0],   req[3:1]};
      2'd2:    req_rot = {req[1:0], req[3:2]};
      2'd3:    req_rot = {req[2:0], req[3]};
      default: req_rot = req;
    endcase
  end

  // Pick the lowest set bit of the rotated vector and map it back to a requester index.
  always_comb begin
    arb_off = 2'd0;
    if (req_rot[0])      arb_off = 2'd0;
    else if (req_rot[1]) arb_off = 2'd1;
    else if (req_rot[2]) arb_off = 2'd2;
    else if (req_rot[3]) arb_off = 2'd3;
    arb_idx   = rr_ptr + arb_off;
    arb_found = |req;
  end

  // Decide whether the current owner keeps the grant or has to be re-arbitrated.
  always_comb begin
    owner_req = req[gnt_idx];
    at_limit  = (hold_cnt >= HOLD_LIMIT);
    keep      = owner_req && (!at_limit || lock_act);
    timeout   = owner_req && at_limit && !lock_act;
  end

  // Arbiter state machine; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
      rr_ptr   <= 2'd0;
      gnt      <= 4'b0000;
      gnt_idx  <= 2'd0;
      gnt_vld  <= 1'b0;
      preempt  <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_found) begin
            gnt      <= 4'(4'b0001 << arb_idx);
            gnt_idx  <= arb_idx;
            gnt_vld  <= 1'b1;
            hold_cnt <= 8'd1;
            rr_ptr   <= arb_idx + 2'd1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (keep) begin
            if (!at_limit) begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end else if (arb_found) begin
            gnt      <= 4'(4'b0001 << arb_idx);
            gnt_idx  <= arb_idx;
            gnt_vld  <= 1'b1;
            hold_cnt <= 8'd1;
            rr_ptr   <= arb_idx + 2'd1;
            preempt  <= timeout && (arb_idx != gnt_idx);
          end else begin
            gnt      <= 4'b0000;
            gnt_idx  <= 2'd0;
            gnt_vld  <= 1'b0;
            hold_cnt <= 8'd0;
            state    <= IDLE;
          end
        end
        default: begin
          gnt      <= 4'b0000;
          gnt_idx  <= 2'd0;
          gnt_vld  <= 1'b0;
          hold_cnt <= 8'd0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4ch.sv
// tb_rr_arbiter_4ch
// Self-checking bench for rr_arbiter_4ch: a behavioural model (owner,
// tenure length, last winner) is compared against the DUT every cycle,
// with directed literal checks from the known scenarios plus random traffic.
// Honours RR_ARB_LOCK_EN the same way the design does.

module tb_rr_arbiter_4ch;

  localparam int MAX_HOLD = 8;

`ifdef RR_ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       lock;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       preempt;

  int tests  = 0;
  int failed = 0;
  bit started = 1'b0;

  typedef struct {
    int         owner;
    int         tenure;
    int         last;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       pre;
  } model_t;

  model_t m;

  rr_arbiter_4ch #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef RR_ARB_LOCK_EN
    .lock    (lock),
`endif
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .preempt (preempt)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic model_t reset_model();
    model_t n;
    n.owner  = -1;
    n.tenure = 0;
    n.last   = 3;
    n.gnt    = 4'b0000;
    n.idx    = 2'd0;
    n.vld    = 1'b0;
    n.pre    = 1'b0;
    return n;
  endfunction

  // One cycle of arbitration described by the rules: who owns, how long, who won last.
  function automatic model_t next_model(model_t cur, logic [3:0] r, logic lk);
    model_t n;
    int     first;
    bit     owner_wants;
    n = cur;
    n.pre = 1'b0;
    owner_wants = (cur.owner >= 0) && r[cur.owner];
    if (owner_wants && (cur.tenure < MAX_HOLD || lk)) begin
      if (cur.tenure < MAX_HOLD) n.tenure = cur.tenure + 1;
    end else begin
      first = -1;
      for (int s = 1; s <= 4; s++) begin
        int c;
        c = (cur.last + s) % 4;
        if (first < 0 && r[c]) first = c;
      end
      if (first >= 0) begin
        n.pre    = owner_wants && (first != cur.owner);
        n.owner  = first;
        n.tenure = 1;
        n.last   = first;
      end else begin
        n.owner  = -1;
        n.tenure = 0;
      end
    end
    n.gnt = (n.owner >= 0) ? 4'(4'b0001 << n.owner) : 4'b0000;
    n.idx = (n.owner >= 0) ? 2'(n.owner) : 2'd0;
    n.vld = (n.owner >= 0);
    return n;
  endfunction

  // Advance the reference model on the same edges that move the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) m <= reset_model();
    else     m <= next_model(m, req, LOCK_ON && lock);
  end

  // Compare every cycle's outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      tests++;
      if ({gnt, gnt_idx, gnt_vld, preempt} !== {m.gnt, m.idx, m.vld, m.pre}) begin
        failed++;
        $display("[TB] FAIL model_cmp t=%0t: gnt=%b idx=%0d vld=%b pre=%b, expected gnt=%b idx=%0d vld=%b pre=%b",
                 $time, gnt, gnt_idx, gnt_vld, preempt, m.gnt, m.idx, m.vld, m.pre);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] r, input logic lk);
    req  = r;
    lock = lk;
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] e_gnt, input logic [1:0] e_idx,
                             input logic e_vld, input logic e_pre);
    tests++;
    if ({gnt, gnt_idx, gnt_vld, preempt} !== {e_gnt, e_idx, e_vld, e_pre}) begin
      failed++;
      $display("[TB] FAIL %s t=%0t: gnt=%b idx=%0d vld=%b pre=%b, expected gnt=%b idx=%0d vld=%b pre=%b",
               name, $time, gnt, gnt_idx, gnt_vld, preempt, e_gnt, e_idx, e_vld, e_pre);
    end
    if (started) begin
      tests++;
      if ({m.gnt, m.idx, m.vld, m.pre} !== {e_gnt, e_idx, e_vld, e_pre}) begin
        failed++;
        $display("[TB] FAIL %s_model t=%0t: model gnt=%b idx=%0d vld=%b pre=%b, expected gnt=%b idx=%0d vld=%b pre=%b",
                 name, $time, m.gnt, m.idx, m.vld, m.pre, e_gnt, e_idx, e_vld, e_pre);
      end
    end
  endtask

  task automatic doReset();
    rst  = 1'b1;
    req  = 4'b0000;
    lock = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Directed scenarios first, then randomized traffic, then the summary.
  initial begin
    int         exp_own [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    logic [3:0] r;
    logic       lk;

    rst  = 1'b1;
    req  = 4'b0000;
    lock = 1'b0;
    doReset();
    started = 1'b1;
    checkOutput("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Two requesters, tenure limit forces alternation with preempt.
    for (int c = 1; c <= 17; c++) begin
      applyStimulus(4'b0101, 1'b0);
      if (c == 1)  checkOutput("hold_c1",  4'b0001, 2'd0, 1'b1, 1'b0);
      if (c == 8)  checkOutput("hold_c8",  4'b0001, 2'd0, 1'b1, 1'b0);
      if (c == 9)  checkOutput("hold_c9",  4'b0100, 2'd2, 1'b1, 1'b1);
      if (c == 10) checkOutput("hold_c10", 4'b0100, 2'd2, 1'b1, 1'b0);
      if (c == 17) checkOutput("hold_c17", 4'b0001, 2'd0, 1'b1, 1'b1);
    end
    applyStimulus(4'b0000, 1'b0);
    checkOutput("to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // All request; each owner drops one cycle after its grant.
    doReset();
    for (int i = 0; i < 10; i++) begin
      r = 4'b1111;
      if (i > 0 && (i % 2) == 0) r[exp_own[i-1]] = 1'b0;
      applyStimulus(r, 1'b0);
      checkOutput("rr_seq", 4'(4'b0001 << exp_own[i]), 2'(exp_own[i]), 1'b1, 1'b0);
    end

    // Lone requester is re-granted at the limit without preempt.
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(4'b0100, 1'b0);
      if (c == 1 || c == 9 || c == 10 || c == 17 || c == 20)
        checkOutput("lone_req", 4'b0100, 2'd2, 1'b1, 1'b0);
    end

    // Owner 1 drops while requester 3 rises, with rr_ptr at 2.
    applyStimulus(4'b0010, 1'b0);
    checkOutput("own1_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("swap_to_3", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a tenure.
    applyStimulus(4'b0010, 1'b0);
    checkOutput("pre_rst", 4'b0010, 2'd1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 checkOutput("async_clr", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 4'b0110;
    @(negedge clk);
    #1;
    checkOutput("post_rst", 4'b0010, 2'd1, 1'b1, 1'b0);

`ifdef RR_ARB_LOCK_EN
    // Lock keeps owner 0 past the limit; its release triggers the timeout.
    doReset();
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(4'b0011, 1'b1);
      checkOutput("locked", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    applyStimulus(4'b0011, 1'b0);
    checkOutput("unlock", 4'b0010, 2'd1, 1'b1, 1'b1);
`endif

    // Random traffic with sticky request patterns so tenures reach the limit.
    doReset();
    r  = 4'b0000;
    lk = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) lk = ~lk;
      applyStimulus(r, lk);
    end
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4ch.md
Name: rr_arbiter_4ch

Overview:
- Round-robin arbiter that shares one downstream resource among four requesters.
- Produces a registered one-hot grant and its 2-bit encoded index. The index is the same encoding a 4:2 encoder yields from the one-hot grant.
- Enforces a per-grant tenure limit so that no single requester can starve the others.
- Sits between the four request sources and the shared datapath/bus mux, which selects on gnt_idx.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant. Legal range 1..255; the internal hold counter is 8 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; req[i]=1 means requester i wants the resource.
- gnt  output  4  one-hot grant, registered; all zeros when nothing is granted.
- gnt_idx  output  2  encoded index of the granted requester. Valid only when gnt_vld=1; held at 0 otherwise.
- gnt_vld  output  1  1 when any grant is active (equals OR of gnt).
- preempt  output  1  one-cycle pulse, registered. Asserted in the first cycle after a grant was withdrawn because MAX_HOLD expired while the owner still requested.

Behaviour:
- Reset (async assert, sync release to the first clk edge):
  - gnt=0, gnt_idx=0, gnt_vld=0, preempt=0.
  - state=IDLE, hold_cnt=0, rr_ptr=0, so requester 0 has highest priority first.
- Priority order is rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3, all mod 4 (2-bit wrap: 3+1=0).
- Arbitration (arb) picks the first set req bit in that order.
- After any grant to index k, rr_ptr becomes k+1 mod 4, so the last owner becomes lowest priority.
- States: IDLE, BUSY.
- IDLE:
  - req=0: stay in IDLE, outputs 0.
  - req!=0: arb. Next cycle gnt=onehot(k), gnt_idx=k, gnt_vld=1, hold_cnt=1, state=BUSY.
  - Grant latency from req assertion is exactly 1 cycle.
- BUSY with owner o:
  - Keep: req[o]=1 and hold_cnt<MAX_HOLD. Grant unchanged; hold_cnt increments.
  - Release: req[o]=0. Re-arbitrate over req in the same cycle.
    - Another request present: new grant appears next cycle with no gap; hold_cnt=1.
    - No request: IDLE next cycle, outputs 0.
  - Timeout: req[o]=1 and hold_cnt==MAX_HOLD. Re-arbitrate in the same cycle; o is lowest priority because rr_ptr=o+1.
    - Another request wins: next cycle grant switches and preempt=1 for one cycle.
    - o is the only requester: o is re-granted, hold_cnt=1, preempt=0.
- A grant therefore lasts at most MAX_HOLD cycles per tenure.
- MAX_HOLD=1 degenerates to strict per-cycle round robin.
- Simultaneous events:
  - Owner drops req in the same cycle another raises it: handled as Release. The new requester is eligible in that same arbitration.
  - Requests raised mid-tenure wait; they never preempt before release or timeout.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_idx equals the encoded gnt.
  - gnt[i]=1 implies req[i] was 1 in the previous cycle.
- rst asserted mid-tenure: all outputs clear immediately (asynchronously). The arbiter restarts from rr_ptr=0.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined: adds input port lock (1 bit).
  - While in BUSY with lock=1 and req[o]=1, the timeout rule is suppressed: no switch, no preempt.
  - hold_cnt saturates at MAX_HOLD.
  - When lock falls with hold_cnt==MAX_HOLD, the timeout rule applies on that cycle.
  - lock is ignored in IDLE.
- Undefined: no lock port; the timeout always applies.

Test Plan:
- Reset then req=4'b0101 held -> cycle 1: gnt=0001, idx=0. Cycle 9 (MAX_HOLD=8): gnt=0100, idx=2, preempt=1 for that cycle. Cycle 17: gnt=0001, preempt=1.
- req=4'b1111 with each owner dropping req one cycle after its grant -> grants 0,1,2,3,0 on consecutive two-cycle tenures. No idle cycle between grants; gnt_vld stays 1.
- Only req[2]=1 for 20 cycles, MAX_HOLD=8 -> gnt=0100 continuously, preempt never asserted. Internal hold_cnt resets to 1 at cycles 9 and 17.
- Owner 1 drops req while req[3] rises in the same cycle (rr_ptr=2) -> next cycle gnt=1000, idx=3, preempt=0.
- rst pulsed mid-tenure while gnt=0010 -> gnt, gnt_idx, gnt_vld clear before the next clk edge. After release with req=4'b0110, first grant is idx=1 (rr_ptr=0).
- RR_ARB_LOCK_EN defined, req=4'b0011, owner 0 with lock=1 for 12 cycles -> gnt stays 0001 past cycle 8. On the cycle lock falls, next cycle gnt=0010 with preempt=1.
